// File: rtl/bitop_pkg.sv
// Shared definitions for the bitop_stream block: operator codes, MODE values
// and the FSM state encoding.
package bitop_pkg;

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_XOR   = 3'd2;
   localparam logic [2:0] OP_NAND  = 3'd3;
   localparam logic [2:0] OP_NOR   = 3'd4;
   localparam logic [2:0] OP_XNOR  = 3'd5;
   localparam logic [2:0] OP_ANDN  = 3'd6;
   localparam logic [2:0] OP_PASSA = 3'd7;

   localparam logic MODE_PAIR = 1'b0;
   localparam logic MODE_FOLD = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FOLD = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

endpackage

// File: rtl/bitop_alu.sv
// Combinational bitwise operator shared by pairwise and fold paths.
module bitop_alu
   import bitop_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] r
);

   // Select the bitwise function named by op.
   always_comb begin
      r = x;
      case (op)
         OP_AND:   r = x & y;
         OP_OR:    r = x | y;
         OP_XOR:   r = x ^ y;
         OP_NAND:  r = ~(x & y);
         OP_NOR:   r = ~(x | y);
         OP_XNOR:  r = ~(x ^ y);
         OP_ANDN:  r = x & ~y;
         OP_PASSA: r = x;
         default:  r = x;
      endcase
   end

endmodule

// File: rtl/bitop_stream.sv
// Streaming bitwise operator with pairwise and fold modes and valid/ready
// handshakes on both sides. The single accumulator register doubles as Y.
// Optional feature: define BITOP_STREAM_PARITY_EN to add output PAR (XOR of Y).
module bitop_stream
   import bitop_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       OP,
   input  logic             MODE,
   input  logic [LEN_W-1:0] FOLD_LEN,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic [LEN_W-1:0] CNT
`ifdef BITOP_STREAM_PARITY_EN
   ,
   output logic             PAR
`endif
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [2:0]       op_q, op_d;
   logic             vld_q, vld_d;
   logic [LEN_W-1:0] effLen;
   logic [LEN_W-1:0] cntInc;
   logic             inFire;
   logic [WIDTH-1:0] aluX, aluY, aluR;
   logic [2:0]       aluOp;

   // A requested fold length of zero behaves like a single-beat fold.
   assign effLen = (FOLD_LEN == '0) ? LEN_W'(1) : FOLD_LEN;
   assign cntInc = cnt_q + LEN_W'(1);
   assign inFire = in_valid & in_ready;

   // During a fold the accumulator is combined with A under the latched op;
   // otherwise the ALU sees the fresh A/B/OP of the offered beat.
   always_comb begin
      aluX  = A;
      aluY  = B;
      aluOp = OP;
      if (state_q == ST_FOLD) begin
         aluX  = acc_q;
         aluY  = A;
         aluOp = op_q;
      end
   end

   bitop_alu #(.WIDTH(WIDTH)) uAlu (
      .x  (aluX),
      .y  (aluY),
      .op (aluOp),
      .r  (aluR)
   );

   // State register; reset drops any fold in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state plus datapath next values for each FSM state.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      op_d    = op_q;
      vld_d   = vld_q;
      case (state_q)
         ST_IDLE: begin
            if (vld_q && out_ready) vld_d = 1'b0;
            if (inFire) begin
               acc_d = aluR;
               cnt_d = LEN_W'(1);
               if (MODE == MODE_PAIR) begin
                  vld_d = 1'b1;
               end else begin
                  vld_d   = 1'b0;
                  op_d    = OP;
                  len_d   = effLen;
                  state_d = (effLen == LEN_W'(1)) ? ST_HOLD : ST_FOLD;
               end
            end
         end
         ST_FOLD: begin
            if (inFire) begin
               acc_d = aluR;
               cnt_d = cntInc;
               if (cntInc == len_q) state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready  = ~vld_q | out_ready;
            out_valid = vld_q;
         end
         ST_FOLD: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
         ST_HOLD: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath registers: accumulator/result, beat count, latched fold setup.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         len_q <= '0;
         op_q  <= OP_AND;
         vld_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         op_q  <= op_d;
         vld_q <= vld_d;
      end
   end

   assign Y   = acc_q;
   assign CNT = cnt_q;

`ifdef BITOP_STREAM_PARITY_EN
   logic par_q;

   // Parity registered alongside Y so it holds whenever Y holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= ^acc_d;
   end

   assign PAR = par_q;
`endif

endmodule

// File: tb/tb_bitop_stream.sv
// Self-checking bench for bitop_stream: directed cases then random traffic
// compared against a transaction-level reference model.
module tb_bitop_stream;

   localparam int WIDTH = 8;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             inValid = 1'b0;
   logic             inReady;
   logic [WIDTH-1:0] opA = '0;
   logic [WIDTH-1:0] opB = '0;
   logic [2:0]       opSel = '0;
   logic             mode = 1'b0;
   logic [LEN_W-1:0] foldLen = '0;
   logic             outValid;
   logic             outReady = 1'b0;
   logic [WIDTH-1:0] yOut;
   logic [LEN_W-1:0] cntOut;
`ifdef BITOP_STREAM_PARITY_EN
   logic             parOut;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Reference model: pending result plus the list of beats of an open fold.
   bit               mHave = 0;
   bit               mIsFold = 0;
   bit               mCollect = 0;
   logic [WIDTH-1:0] mY = '0;
   int               mCnt = 0;
   logic [WIDTH-1:0] beats[$];
   logic [WIDTH-1:0] fB;
   logic [2:0]       fOp;
   int               fLen;

   bitop_stream #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .A         (opA),
      .B         (opB),
      .OP        (opSel),
      .MODE      (mode),
      .FOLD_LEN  (foldLen),
      .out_valid (outValid),
      .out_ready (outReady),
      .Y         (yOut),
      .CNT       (cntOut)
`ifdef BITOP_STREAM_PARITY_EN
      ,
      .PAR       (parOut)
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] refOp(input logic [2:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
      case (op)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x & y);
         3'd4:    return ~(x | y);
         3'd5:    return ~(x ^ y);
         3'd6:    return x & ~y;
         default: return x;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] act,
                              input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic finishFold();
      logic [WIDTH-1:0] r;
      r = refOp(fOp, beats[0], fB);
      for (int i = 1; i < beats.size(); i++) r = refOp(fOp, r, beats[i]);
      mHave    = 1;
      mIsFold  = 1;
      mCollect = 0;
      mY       = r;
      mCnt     = fLen;
   endtask

   // One cycle: drive inputs, compare outputs with the model, advance the model.
   task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [2:0] op,
                                input logic md, input logic [LEN_W-1:0] len,
                                input logic ordy);
      bit expReady;
      bit accept;
      @(negedge clk);
      inValid = iv; opA = a; opB = b; opSel = op; mode = md;
      foldLen = len; outReady = ordy;
      #1;
      expReady = mCollect ? 1'b1 : ((mHave && mIsFold) ? 1'b0 : (!mHave || ordy));
      checkOutput("in_ready", 64'(inReady), 64'(expReady));
      checkOutput("out_valid", 64'(outValid), 64'(mHave));
      if (mHave) begin
         checkOutput("Y", 64'(yOut), 64'(mY));
         checkOutput("CNT", 64'(cntOut), 64'(mCnt));
`ifdef BITOP_STREAM_PARITY_EN
         checkOutput("PAR", 64'(parOut), 64'(^mY));
`endif
      end
      @(posedge clk);
      accept = iv && expReady;
      if (mHave && ordy) mHave = 0;
      if (accept) begin
         if (mCollect) begin
            beats.push_back(a);
            if (beats.size() == fLen) finishFold();
         end else if (md == 1'b0) begin
            mHave   = 1;
            mIsFold = 0;
            mY      = refOp(op, a, b);
            mCnt    = 1;
         end else begin
            fLen = (len == 0) ? 1 : int'(len);
            fOp  = op;
            fB   = b;
            beats.delete();
            beats.push_back(a);
            if (fLen == 1) finishFold();
            else mCollect = 1;
         end
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      inValid = 1'b0;
      #1;
      checkOutput("rst_out_valid", 64'(outValid), 64'd0);
      checkOutput("rst_Y", 64'(yOut), 64'd0);
      checkOutput("rst_CNT", 64'(cntOut), 64'd0);
      checkOutput("rst_in_ready", 64'(inReady), 64'd1);
      mHave = 0;
      mCollect = 0;
      beats.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      $display("[TB] start");
      applyReset();

      // Pairwise AND 1F & E0.
      applyStimulus(1, 8'h1F, 8'hE0, 3'd0, 0, 4'd0, 1);
      #1;
      checkOutput("pair_and_valid", 64'(outValid), 64'd1);
      checkOutput("pair_and_Y", 64'(yOut), 64'h00);
      checkOutput("pair_and_CNT", 64'(cntOut), 64'd1);

      // Pairwise XOR DF ^ 2C stalled for three cycles.
      applyStimulus(1, 8'hDF, 8'h2C, 3'd2, 0, 4'd0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'h11, 8'h22, 3'd0, 0, 4'd0, 0);
      #1;
      checkOutput("stall_Y", 64'(yOut), 64'hF3);
      checkOutput("stall_in_ready", 64'(inReady), 64'd0);
      applyStimulus(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);

      // Fold OR of 01|02, 04, 80 over three beats.
      applyStimulus(1, 8'h01, 8'h02, 3'd1, 1, 4'd3, 1);
      applyStimulus(1, 8'h04, 8'hFF, 3'd0, 0, 4'd9, 1);
      applyStimulus(1, 8'h80, 8'hFF, 3'd5, 1, 4'd1, 0);
      #1;
      checkOutput("fold_or_Y", 64'(yOut), 64'h87);
      checkOutput("fold_or_CNT", 64'(cntOut), 64'd3);
      checkOutput("fold_or_in_ready", 64'(inReady), 64'd0);
      applyStimulus(1, 8'h55, 8'h55, 3'd0, 0, 4'd0, 0);
      applyStimulus(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);

      // Zero fold length acts as a single beat.
      applyStimulus(1, 8'hAA, 8'h55, 3'd2, 1, 4'd0, 1);
      #1;
      checkOutput("fold0_Y", 64'(yOut), 64'hFF);
      checkOutput("fold0_CNT", 64'(cntOut), 64'd1);
      applyStimulus(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);

      // Maximum fold length: fifteen beats, count must reach 15.
      applyStimulus(1, 8'h01, 8'h00, 3'd1, 1, 4'd15, 1);
      for (int i = 1; i < 15; i++)
         applyStimulus(1, 8'(i), 8'h00, 3'd0, 0, 4'd0, 1);
      #1;
      checkOutput("foldmax_CNT", 64'(cntOut), 64'd15);
      checkOutput("foldmax_Y", 64'(yOut), 64'h0F);
      applyStimulus(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);

      // Reset after two of four fold beats, then a normal pairwise beat.
      applyStimulus(1, 8'h0F, 8'hF0, 3'd2, 1, 4'd4, 1);
      applyStimulus(1, 8'h33, 8'h00, 3'd0, 0, 4'd0, 1);
      applyReset();
      applyStimulus(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);
      applyStimulus(1, 8'h3C, 8'h0F, 3'd6, 0, 4'd0, 1);
      #1;
      checkOutput("post_rst_Y", 64'(yOut), 64'h30);
      checkOutput("post_rst_CNT", 64'(cntOut), 64'd1);

`ifdef BITOP_STREAM_PARITY_EN
      applyStimulus(1, 8'h07, 8'h00, 3'd7, 0, 4'd0, 1);
      #1;
      checkOutput("par_07", 64'(parOut), 64'd1);
      applyStimulus(1, 8'h03, 8'h00, 3'd7, 0, 4'd0, 1);
      #1;
      checkOutput("par_03", 64'(parOut), 64'd0);
`endif

      // Random traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            applyReset();
         end else begin
            applyStimulus(1'($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                          3'($urandom), 1'($urandom_range(0, 3) == 0),
                          4'($urandom_range(0, 6)), 1'($urandom_range(0, 9) < 6));
         end
      end
      applyStimulus(0, 8'h00, 8'h00, 3'd0, 0, 4'd0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
